// File: rtl/alu_issue_seq.sv
// alu_issue_seq: operand-fetch/issue/writeback sequencer for the 8-bit ALU; `ALU_ISSUE_IMM_OPERAND_EN` lets use_imm pick imm as operand b
module alu_issue_seq #(
  parameter int NREG = 8,
  parameter int DW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [3:0]              opcode,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic [DW-1:0]           imm,
  input  logic                    use_imm,
  output logic                    alu_en,
  output logic [3:0]              alu_fn,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic                    alu_cmpflag,
  input  logic [DW-1:0]           alu_out,
  output logic                    done,
  output logic                    err,
  output logic                    zero_flag,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
);
  localparam int AW = $clog2(NREG);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_WAIT = 3'd3, S_WB = 3'd4;
  localparam logic [3:0] OP_CMP = 4'd8, OP_LDI = 4'd9;
  logic [2:0] state;
  logic [3:0] op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q;
  logic [DW-1:0] imm_q;
  logic use_imm_q;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] opa, opb;
  logic is_alu, is_cmp, is_ldi;
  assign is_alu = !op_q[3];
  assign is_cmp = op_q == OP_CMP;
  assign is_ldi = op_q == OP_LDI;
  assign instr_ready = (state == S_IDLE) && !reset;
  assign opa = regs[rs1_q];
  assign dbg_data = regs[dbg_addr];
`ifdef ALU_ISSUE_IMM_OPERAND_EN
  assign opb = use_imm_q ? imm_q : regs[rs2_q];
`else
  logic unused_use_imm;
  assign unused_use_imm = use_imm_q;
  assign opb = regs[rs2_q];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      alu_en <= 1'b0;
      alu_fn <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_cmpflag <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
      zero_flag <= 1'b0;
      op_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      use_imm_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      alu_en <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) begin
          op_q <= opcode;
          rd_q <= rd;
          rs1_q <= rs1;
          rs2_q <= rs2;
          imm_q <= imm;
          use_imm_q <= use_imm;
          state <= S_FETCH;
        end
        S_FETCH: if (is_ldi) state <= S_WB;
        else if (is_alu || is_cmp) begin
          state <= S_EXEC;
          alu_en <= 1'b1;
          alu_a <= opa;
          alu_b <= opb;
          alu_fn <= is_cmp ? 4'd1 : op_q;
          alu_cmpflag <= is_cmp ? (opa != opb) : 1'b1;
        end else begin
          err <= 1'b1;
          state <= S_IDLE;
        end
        S_EXEC: state <= S_WAIT;
        // ALU result register settled during WAIT; commit on leaving it
        S_WAIT: begin
          state <= S_WB;
          done <= 1'b1;
          if (is_cmp) zero_flag <= !alu_cmpflag;
          else begin
            regs[rd_q] <= alu_out;
            zero_flag <= alu_out == '0;
          end
        end
        S_WB: begin
          state <= S_IDLE;
          if (is_ldi) begin
            regs[rd_q] <= imm_q;
            zero_flag <= imm_q == '0;
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: scoreboard bench for alu_issue_seq with a behavioural ALU model
module tb_alu_issue_seq;
  logic clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, use_imm = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0;
  logic [7:0] imm = '0, alu_res = '0, dbg_data, alu_a, alu_b;
  logic instr_ready, alu_en, alu_cmpflag, done, err, zero_flag;
  logic [3:0] alu_fn;
  int n_chk = 0, n_fail = 0, cyc = 0, last_acc = 0, gap_exp = 0;
  bit b2b = 0;
  logic [7:0] m [8];
  typedef struct {
    bit is_err;
    bit has_alu;
    logic [3:0] fn;
    logic cmpf;
    logic [7:0] a;
    logic [7:0] b;
    int lat;
    int acc;
    logic z;
    logic [63:0] regs;
  } exp_t;
  exp_t sb [$];
`ifdef ALU_ISSUE_IMM_OPERAND_EN
  localparam logic [7:0] IMM_B = 8'h10, IMM_RES = 8'h15;
`else
  localparam logic [7:0] IMM_B = 8'h01, IMM_RES = 8'h06;
`endif

  alu_issue_seq dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm),
    .alu_en(alu_en), .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_cmpflag(alu_cmpflag),
    .alu_out(alu_res), .done(done), .err(err), .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a << 1;
      4'd5: return a >> 1;
      4'd6: return a - 8'd1;
      4'd7: return a + 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) if (alu_en) alu_res <= alu_f(alu_fn, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // retire monitor: every done/err must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && (done || err)) begin
      if (sb.size() == 0) fail_now("unexpected_retire");
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("retire_err", 32'(err), 32'(e.is_err));
        chk("retire_done", 32'(done), 32'(!e.is_err));
        chk("retire_latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("zero_flag", 32'(zero_flag), 32'(e.z));
        for (int r = 0; r < 8; r++) begin
          dbg_addr = 3'(r);
          #1;
          chk($sformatf("reg%0d", r), 32'(dbg_data), 32'(e.regs[r*8 +: 8]));
        end
      end
    end
  end

  // ALU-issue monitor: pulse width and issued operands
  bit prev_en = 0;
  int en_run = 0;
  always @(negedge clk) begin
    if (alu_en && !prev_en) begin
      if (sb.size() == 0) fail_now("alu_en_without_instr");
      else begin
        chk("alu_en_allowed", 32'(1), 32'(sb[0].has_alu));
        if (sb[0].has_alu) begin
          chk("alu_fn", 32'(alu_fn), 32'(sb[0].fn));
          chk("alu_cmpflag", 32'(alu_cmpflag), 32'(sb[0].cmpf));
          chk("alu_a", 32'(alu_a), 32'(sb[0].a));
          chk("alu_b", 32'(alu_b), 32'(sb[0].b));
        end
      end
    end
    if (!alu_en && prev_en) chk("alu_en_width", 32'(en_run), 32'(1));
    en_run = alu_en ? en_run + 1 : 0;
    prev_en = alu_en;
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [7:0] im, input logic ui, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] res, input logic z);
    exp_t e;
    int w;
    @(negedge clk);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; use_imm = ui; instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      fail_now("accept_timeout");
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    opcode = 4'hF; rd = ~d; rs1 = ~s1; rs2 = ~s2; imm = ~im; use_imm = ~ui;
    if (b2b) chk("issue_gap", 32'(cyc - last_acc), 32'(gap_exp));
    b2b = 1;
    last_acc = cyc;
    gap_exp = op <= 4'd8 ? 5 : op == 4'd9 ? 3 : 2;
    if (op <= 4'd7 || op == 4'd9) m[d] = res;
    e.is_err = op > 4'd9;
    e.has_alu = op <= 4'd8;
    e.fn = op == 4'd8 ? 4'd1 : op;
    e.cmpf = op == 4'd8 ? (ea != eb) : 1'b1;
    e.a = ea;
    e.b = eb;
    e.lat = op <= 4'd8 ? 3 : op == 4'd9 ? 2 : 1;
    e.acc = cyc;
    e.z = z;
    for (int r = 0; r < 8; r++) e.regs[r*8 +: 8] = m[r];
    sb.push_back(e);
  endtask

  initial begin
    int w;
    for (int r = 0; r < 8; r++) m[r] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'(0));
    chk("rst_alu_en", 32'(alu_en), 32'(0));
    chk("rst_alu_fn", 32'(alu_fn), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_b", 32'(alu_b), 32'(0));
    chk("rst_cmpflag", 32'(alu_cmpflag), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_zero_flag", 32'(zero_flag), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    //    op    rd    rs1   rs2   imm    ui    a      b      res    z
    issue(4'd9, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0, 8'h00, 8'h00, 8'h05, 1'b0);
    issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h03, 1'b0, 8'h00, 8'h00, 8'h03, 1'b0);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'h05, 8'h03, 8'h08, 1'b0);
    issue(4'd9, 3'd1, 3'd0, 3'd0, 8'h2A, 1'b0, 8'h00, 8'h00, 8'h2A, 1'b0);
    issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h2A, 1'b0, 8'h00, 8'h00, 8'h2A, 1'b0);
    issue(4'd8, 3'd6, 3'd1, 3'd2, 8'h00, 1'b0, 8'h2A, 8'h2A, 8'h00, 1'b1);
    issue(4'd8, 3'd6, 3'd1, 3'd3, 8'h00, 1'b0, 8'h2A, 8'h08, 8'h00, 1'b0);
    issue(4'd1, 3'd4, 3'd1, 3'd1, 8'h00, 1'b0, 8'h2A, 8'h2A, 8'h00, 1'b1);
    issue(4'd7, 3'd4, 3'd4, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
    issue(4'hC, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    issue(4'd2, 3'd6, 3'd1, 3'd3, 8'h00, 1'b0, 8'h2A, 8'h08, 8'h08, 1'b0);
    issue(4'd3, 3'd7, 3'd1, 3'd3, 8'h00, 1'b0, 8'h2A, 8'h08, 8'h2A, 1'b0);
    issue(4'd4, 3'd0, 3'd3, 3'd2, 8'h00, 1'b0, 8'h08, 8'h2A, 8'h10, 1'b0);
    issue(4'd5, 3'd3, 3'd3, 3'd1, 8'h00, 1'b0, 8'h08, 8'h2A, 8'h04, 1'b0);
    issue(4'd6, 3'd2, 3'd2, 3'd0, 8'h00, 1'b0, 8'h2A, 8'h10, 8'h29, 1'b0);
    issue(4'd0, 3'd3, 3'd3, 3'd3, 8'h00, 1'b0, 8'h04, 8'h04, 8'h08, 1'b0);
    issue(4'd1, 3'd5, 3'd3, 3'd6, 8'h00, 1'b0, 8'h08, 8'h08, 8'h00, 1'b1);
    issue(4'd9, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0, 8'h00, 8'h00, 8'h05, 1'b0);
    issue(4'd9, 3'd2, 3'd0, 3'd0, 8'h01, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
    issue(4'd0, 3'd5, 3'd1, 3'd2, 8'h10, 1'b1, 8'h05, IMM_B, IMM_RES, 1'b0);
    // abort an ADD while it is in EXEC
    issue(4'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'h05, 8'h01, 8'h06, 1'b0);
    w = 0;
    while (!alu_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!alu_en) fail_now("exec_wait_timeout");
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_alu_en", 32'(alu_en), 32'(0));
    chk("midrst_instr_ready", 32'(instr_ready), 32'(0));
    @(negedge clk);
    chk("midrst_done", 32'(done), 32'(0));
    @(posedge clk);
    #1;
    chk("midrst_done2", 32'(done), 32'(0));
    chk("midrst_cmpflag", 32'(alu_cmpflag), 32'(1));
    chk("midrst_zero_flag", 32'(zero_flag), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int r = 0; r < 8; r++) m[r] = 8'h00;
    b2b = 0;
    repeat (4) @(negedge clk);
    issue(4'd9, 3'd0, 3'd0, 3'd0, 8'h77, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0);
    issue(4'd0, 3'd1, 3'd0, 3'd0, 8'h00, 1'b0, 8'h77, 8'h77, 8'hEE, 1'b0);
    issue(4'd9, 3'd7, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    #10;
    if (sb.size() != 0) fail_now("scoreboard_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
